seg_scan_display_ctrl: RTL and testbench

Parametrised multi-digit seven-segment scan controller; next generation of the fixed 8-digit scanner. Takes a packed hex-nibble word from the datapath (e.g. ALU result) and time-multiplexes it onto one shared segment bus. Adds double-buffered, tear-free update, hex decoding, decimal points, leading-zero suppression, anti-ghost blanking and PWM brightness. Sits between the core datapath and the board display pins.

---
 rtl/seg_scan_display_ctrl.sv | 169 ++++++++++++++++
 tb/tb_seg_scan_display_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display_ctrl.sv
// Seven-segment scan controller: double-buffered hex digits, LZ suppression, anti-ghost blank, PWM dim.
// Latency: which/seg registered (1 cycle); loads apply at next frame boundary; no backpressure, load always accepted.
module seg_scan_display_ctrl #(
    parameter int DIGITS    = 8,
    parameter int SEL_W     = 3,
    parameter int DIV_W     = 11,
    parameter int BRIGHT_W  = 3,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  lz_en,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [SEL_W-1:0]      which,
    output logic [7:0]            seg,
    output logic                  frame_done
);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(DIGITS - 1);

    logic [DIV_W-1:0]    r_div;
    logic [SEL_W-1:0]    r_which;
    logic [7:0]          r_seg;
    logic                r_frame_done;
    logic [4*DIGITS-1:0] r_stage_dat;
    logic [DIGITS-1:0]   r_stage_dp;
    logic [4*DIGITS-1:0] r_act_dat;
    logic [DIGITS-1:0]   r_act_dp;
    logic                r_pend;

    logic [DIV_W-1:0]    w_div_nxt;
    logic                w_wrap;
    logic                w_boundary;
    logic [SEL_W-1:0]    w_which_nxt;
    logic [4*DIGITS-1:0] w_act_dat_nxt;
    logic [DIGITS-1:0]   w_act_dp_nxt;
    logic [DIGITS-1:0]   w_lead_zero;
    logic [3:0]          w_nib;
    logic                w_dp;
    logic                w_lz_blank;
    logic                w_in_blank;
    logic                w_pwm_off;
    logic [7:0]          w_seg_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        s = 7'h7F;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign w_div_nxt   = r_div + 1'b1;
    assign w_wrap      = &r_div;
    assign w_boundary  = w_wrap && (r_which == LAST_SEL);
    assign w_which_nxt = !w_wrap ? r_which :
                         (r_which == LAST_SEL) ? '0 : r_which + 1'b1;

    // A load on the boundary cycle bypasses staging so it is never a frame late.
    always_comb begin
        w_act_dat_nxt = r_act_dat;
        w_act_dp_nxt  = r_act_dp;
        if (w_boundary) begin
            if (load) begin
                w_act_dat_nxt = data_in;
                w_act_dp_nxt  = dp_in;
            end else if (r_pend) begin
                w_act_dat_nxt = r_stage_dat;
                w_act_dp_nxt  = r_stage_dp;
            end
        end
    end

    // Digit 0 is leftmost and shows the most significant nibble.
    always_comb begin
        logic v_run;
        v_run       = 1'b1;
        w_lead_zero = '0;
        for (int k = 0; k < DIGITS; k++) begin
            v_run          = v_run & (w_act_dat_nxt[4*(DIGITS-1-k) +: 4] == 4'h0);
            w_lead_zero[k] = v_run;
        end
    end

    always_comb begin
        w_nib      = 4'h0;
        w_dp       = 1'b0;
        w_lz_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_which_nxt == SEL_W'(k)) begin
                w_nib      = w_act_dat_nxt[4*(DIGITS-1-k) +: 4];
                w_dp       = w_act_dp_nxt[k];
                w_lz_blank = lz_en && w_lead_zero[k] && (k != DIGITS - 1);
            end
        end
    end

    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign w_in_blank = 1'b0;
        end else begin : g_blank
            localparam logic [DIV_W-1:0] BLANK_V = DIV_W'(BLANK_CYC);
            assign w_in_blank = (w_div_nxt < BLANK_V);
        end
    endgenerate

    assign w_pwm_off = (w_div_nxt[DIV_W-1 -: BRIGHT_W] > bright);

    always_comb begin
        w_seg_nxt = 8'hFF;
        if (!(w_in_blank || w_pwm_off || w_lz_blank)) begin
            w_seg_nxt = {~w_dp, hex7(w_nib)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div        <= '0;
            r_which      <= '0;
            r_seg        <= 8'hFF;
            r_frame_done <= 1'b0;
            r_stage_dat  <= '0;
            r_stage_dp   <= '0;
            r_act_dat    <= '0;
            r_act_dp     <= '0;
            r_pend       <= 1'b0;
        end else begin
            r_div        <= w_div_nxt;
            r_which      <= w_which_nxt;
            r_seg        <= w_seg_nxt;
            r_frame_done <= w_boundary;
            r_act_dat    <= w_act_dat_nxt;
            r_act_dp     <= w_act_dp_nxt;
            if (load) begin
                r_stage_dat <= data_in;
                r_stage_dp  <= dp_in;
            end
            if (w_boundary) begin
                r_pend <= 1'b0;
            end else if (load) begin
                r_pend <= 1'b1;
            end
        end
    end

    assign which      = r_which;
    assign seg        = r_seg;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_display_ctrl.sv
// Directed bench: instance A (8 digits, 2-cycle blank) for reset/decode/load/LZ,
// instance B (5 digits, 2-bit brightness, no blank) for scan wrap and PWM.
`timescale 1ns/1ps
module tb_seg_scan_display_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pos_a = 0;
    int pos_b = 0;

    logic        rst_a    = 1'b1;
    logic [31:0] data_a   = '0;
    logic [7:0]  dp_a     = '0;
    logic        load_a   = 1'b0;
    logic        lz_a     = 1'b0;
    logic [2:0]  bright_a = 3'd7;
    logic [2:0]  which_a;
    logic [7:0]  seg_a;
    logic        fd_a;

    logic        rst_b    = 1'b1;
    logic [19:0] data_b   = '0;
    logic [4:0]  dp_b     = '0;
    logic        load_b   = 1'b0;
    logic        lz_b     = 1'b0;
    logic [1:0]  bright_b = 2'd3;
    logic [2:0]  which_b;
    logic [7:0]  seg_b;
    logic        fd_b;

    seg_scan_display_ctrl #(.DIGITS(8), .SEL_W(3), .DIV_W(4), .BRIGHT_W(3), .BLANK_CYC(2)) u_a (
        .clk(clk), .rst(rst_a), .data_in(data_a), .dp_in(dp_a), .load(load_a),
        .lz_en(lz_a), .bright(bright_a), .which(which_a), .seg(seg_a), .frame_done(fd_a)
    );

    seg_scan_display_ctrl #(.DIGITS(5), .SEL_W(3), .DIV_W(4), .BRIGHT_W(2), .BLANK_CYC(0)) u_b (
        .clk(clk), .rst(rst_b), .data_in(data_b), .dp_in(dp_b), .load(load_b),
        .lz_en(lz_b), .bright(bright_b), .which(which_b), .seg(seg_b), .frame_done(fd_b)
    );

    // One clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        pos_a = rst_a ? 0 : pos_a + 1;
        pos_b = rst_b ? 0 : pos_b + 1;
    endtask

    task automatic goto_a(input int w, input int d);
        int n;
        n = ((w * 16 + d) - (pos_a % 128) + 128) % 128;
        repeat (n) step();
    endtask

    task automatic goto_b(input int w, input int d);
        int n;
        n = ((w * 16 + d) - (pos_b % 80) + 80) % 80;
        repeat (n) step();
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) step();
        total++; if (which_a !== 3'd0) begin bad++; $display("FAIL reset_which got=%0d exp=0", which_a); end
        total++; if (seg_a !== 8'hFF) begin bad++; $display("FAIL reset_seg got=%h exp=ff", seg_a); end
        total++; if (fd_a !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b exp=0", fd_a); end
        rst_a = 1'b0;
        rst_b = 1'b0;
        goto_a(2, 7);
        data_a = 32'hFFFF_FFFF; dp_a = 8'hFF; load_a = 1'b1;
        step();
        load_a = 1'b0;
        rst_a = 1'b1;
        repeat (3) step();
        total++; if (which_a !== 3'd0) begin bad++; $display("FAIL midreset_which got=%0d exp=0", which_a); end
        total++; if (seg_a !== 8'hFF) begin bad++; $display("FAIL midreset_seg got=%h exp=ff", seg_a); end
        total++; if (fd_a !== 1'b0) begin bad++; $display("FAIL midreset_fd got=%b exp=0", fd_a); end
        rst_a = 1'b0;
        repeat (15) step();
        total++; if (which_a !== 3'd0) begin bad++; $display("FAIL reset_cyc15_which got=%0d exp=0", which_a); end
        step();
        total++; if (which_a !== 3'd1) begin bad++; $display("FAIL reset_cyc16_which got=%0d exp=1", which_a); end
        goto_a(0, 5);
        total++; if (seg_a !== 8'hC0) begin bad++; $display("FAIL reset_discard_pending got=%h exp=c0", seg_a); end
    endtask

    task automatic test_decode();
        logic [7:0] exp_seg [8] = '{8'h40, 8'hF9, 8'hA4, 8'hB0, 8'h80, 8'h90, 8'h88, 8'h8E};
        goto_a(4, 0);
        data_a = 32'h0123_89AF; dp_a = 8'h01; load_a = 1'b1;
        step();
        load_a = 1'b0;
        goto_a(0, 0);
        total++; if (seg_a !== 8'hFF) begin bad++; $display("FAIL dec_blank0 got=%h exp=ff", seg_a); end
        total++; if (fd_a !== 1'b1) begin bad++; $display("FAIL dec_fd_pulse got=%b exp=1", fd_a); end
        step();
        total++; if (seg_a !== 8'hFF) begin bad++; $display("FAIL dec_blank1 got=%h exp=ff", seg_a); end
        total++; if (fd_a !== 1'b0) begin bad++; $display("FAIL dec_fd_low got=%b exp=0", fd_a); end
        step();
        total++; if (seg_a !== exp_seg[0]) begin bad++; $display("FAIL dec_digit0 got=%h exp=%h", seg_a, exp_seg[0]); end
        for (int k = 1; k < 8; k++) begin
            goto_a(k, 5);
            total++; if (which_a !== 3'(k)) begin bad++; $display("FAIL dec_which%0d got=%0d exp=%0d", k, which_a, k); end
            total++; if (seg_a !== exp_seg[k]) begin bad++; $display("FAIL dec_digit%0d got=%h exp=%h", k, seg_a, exp_seg[k]); end
        end
    endtask

    task automatic test_tear_free();
        logic [7:0] old_seg [4] = '{8'h80, 8'h90, 8'h88, 8'h8E};
        goto_a(3, 8);
        data_a = 32'h7654_3210; dp_a = 8'h80; load_a = 1'b1;
        step();
        load_a = 1'b0;
        for (int k = 4; k < 8; k++) begin
            goto_a(k, 5);
            total++; if (seg_a !== old_seg[k-4]) begin bad++; $display("FAIL tear_old_digit%0d got=%h exp=%h", k, seg_a, old_seg[k-4]); end
        end
        goto_a(0, 5);
        total++; if (seg_a !== 8'hF8) begin bad++; $display("FAIL tear_new_digit0 got=%h exp=f8", seg_a); end
        goto_a(4, 5);
        total++; if (seg_a !== 8'hB0) begin bad++; $display("FAIL tear_new_digit4 got=%h exp=b0", seg_a); end
        goto_a(7, 5);
        total++; if (seg_a !== 8'h40) begin bad++; $display("FAIL tear_new_digit7 got=%h exp=40", seg_a); end
        goto_a(7, 15);
        data_a = 32'hE000_0000; dp_a = 8'h00; load_a = 1'b1;
        step();
        load_a = 1'b0;
        total++; if (fd_a !== 1'b1) begin bad++; $display("FAIL bnd_fd got=%b exp=1", fd_a); end
        goto_a(0, 5);
        total++; if (seg_a !== 8'h86) begin bad++; $display("FAIL bnd_load_digit0 got=%h exp=86", seg_a); end
        goto_a(1, 5);
        total++; if (seg_a !== 8'hC0) begin bad++; $display("FAIL bnd_load_digit1 got=%h exp=c0", seg_a); end
    endtask

    task automatic test_lz();
        logic [7:0] exp1 [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h92, 8'hC0};
        goto_a(4, 0);
        data_a = 32'h0000_0050; dp_a = 8'h01; lz_a = 1'b1; load_a = 1'b1;
        step();
        load_a = 1'b0;
        for (int k = 0; k < 8; k++) begin
            goto_a(k, 5);
            total++; if (seg_a !== exp1[k]) begin bad++; $display("FAIL lz50_digit%0d got=%h exp=%h", k, seg_a, exp1[k]); end
        end
        goto_a(4, 0);
        data_a = 32'h0; dp_a = 8'h00; load_a = 1'b1;
        step();
        load_a = 1'b0;
        for (int k = 0; k < 8; k++) begin
            goto_a(k, 5);
            total++; if (seg_a !== ((k == 7) ? 8'hC0 : 8'hFF)) begin bad++; $display("FAIL lz0_digit%0d got=%h exp=%h", k, seg_a, (k == 7) ? 8'hC0 : 8'hFF); end
        end
        goto_a(2, 5);
        lz_a = 1'b0;
        step();
        total++; if (seg_a !== 8'hC0) begin bad++; $display("FAIL lz_live_off got=%h exp=c0", seg_a); end
    endtask

    task automatic test_scan_wrap();
        int exp_w;
        logic exp_fd;
        bright_b = 2'd3;
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        for (int i = 0; i < 170; i++) begin
            step();
            exp_w  = (pos_b / 16) % 5;
            exp_fd = ((pos_b % 80) == 0);
            total++; if (which_b !== 3'(exp_w)) begin bad++; $display("FAIL scan_which cyc=%0d got=%0d exp=%0d", pos_b, which_b, exp_w); end
            total++; if (fd_b !== exp_fd) begin bad++; $display("FAIL scan_fd cyc=%0d got=%b exp=%b", pos_b, fd_b, exp_fd); end
        end
    endtask

    task automatic test_brightness();
        logic [7:0] e;
        goto_b(1, 15);
        bright_b = 2'd1;
        for (int d = 0; d < 16; d++) begin
            step();
            e = (d < 8) ? 8'hC0 : 8'hFF;
            total++; if (seg_b !== e) begin bad++; $display("FAIL bright1_div%0d got=%h exp=%h", d, seg_b, e); end
        end
        bright_b = 2'd3;
        for (int d = 0; d < 16; d++) begin
            step();
            total++; if (seg_b !== 8'hC0) begin bad++; $display("FAIL bright3_div%0d got=%h exp=c0", d, seg_b); end
        end
        bright_b = 2'd0;
        for (int d = 0; d < 16; d++) begin
            step();
            e = (d < 4) ? 8'hC0 : 8'hFF;
            total++; if (seg_b !== e) begin bad++; $display("FAIL bright0_div%0d got=%h exp=%h", d, seg_b, e); end
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_tear_free();
        test_lz();
        test_scan_wrap();
        test_brightness();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
